time_set_ctrl: RTL

Mode and key-sequencing controller for the 12 MHz digital clock. It turns three debounced key levels (mode, up, down) into single-cycle hour/minute adjust commands for the timekeeping counter. It stops seconds counting while the user is setting the time and produces per-digit blink enables for the 6-digit display multiplexer. It sits between the debouncers and the timekeeping and refresh blocks, and replaces direct key-to-counter wiring.

---
 rtl/clock_pkg.sv | 39 +++
 rtl/time_set_ctrl_if.sv | 33 +++
 rtl/time_set_ctrl_key_repeat.sv | 87 ++++++++
 rtl/time_set_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock key/mode path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package clock_pkg;

  // Current setting mode, also driven out to the display path.
  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  // blink_mask layout: one bit per digit, two digits per field.
  localparam int BM_W       = 6;
  localparam int BM_HR_LSB  = 4;
  localparam int BM_MIN_LSB = 2;
  localparam int BM_SEC_LSB = 0;

  // Default timing for the 12 MHz board. A build at another frequency
  // overrides all five timing parameters together.
  localparam int DEF_CLK_HZ         = 12_000_000;
  localparam int DEF_HOLD_CYCLES    = DEF_CLK_HZ / 2;
  localparam int DEF_REPEAT_CYCLES  = DEF_CLK_HZ / 8;
  localparam int DEF_BLINK_CYCLES   = DEF_CLK_HZ / 4;
  localparam int DEF_TIMEOUT_CYCLES = 10 * DEF_CLK_HZ;

  // The four adjust commands towards the timekeeping counter.
  typedef struct packed {
    logic hour_inc;
    logic hour_dec;
    logic min_inc;
    logic min_dec;
  } adj_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key levels in, adjust/run/blink commands out, for the time-set controller.
// Latency: n/a (signal bundle).
// Backpressure: none; levels and single-cycle pulses, no ready path.
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic            mode_lvl;
  logic            up_lvl;
  logic            dn_lvl;
  logic            hour_inc;
  logic            hour_dec;
  logic            min_inc;
  logic            min_dec;
  logic            sec_clear;
  logic            run_en;
  logic [BM_W-1:0] blink_mask;
  mode_t           mode;

  // Key side: debouncers drive levels, timekeeping/display consume commands.
  modport master (
    output mode_lvl, up_lvl, dn_lvl,
    input  hour_inc, hour_dec, min_inc, min_dec,
    input  sec_clear, run_en, blink_mask, mode
  );

  // Controller side.
  modport slave (
    input  mode_lvl, up_lvl, dn_lvl,
    output hour_inc, hour_dec, min_inc, min_dec,
    output sec_clear, run_en, blink_mask, mode
  );

endinterface

// File: rtl/time_set_ctrl_key_repeat.sv
// Per-key press detect, lockout and hold/auto-repeat timing.
// Latency: fire is combinational from the level and local state; caller registers it.
// Backpressure: none; a fire not consumed by the caller is simply lost.
module key_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,      // debounced key level
  input  logic inhibit,  // up and down held together
  input  logic lock,     // mode is changing this cycle
  output logic press,    // raw rising edge, independent of lockout
  output logic fire      // accepted press or repeat
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  logic             prev_q;
  logic             locked_q, locked_n;
  logic             active_q, active_n;
  logic             rep_q, rep_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  // prev_q resets high so a key held through reset release is not a press.
  assign press = lvl & ~prev_q;

  // Lockout and repeat sequencing; cnt counts held cycles since the last fire.
  always_comb begin
    locked_n = locked_q;
    active_n = active_q;
    rep_n    = rep_q;
    cnt_n    = cnt_q;
    fire     = 1'b0;
    if (!lvl) begin
      // Release ends any lockout and clears the repeat state.
      locked_n = 1'b0;
      active_n = 1'b0;
      rep_n    = 1'b0;
      cnt_n    = '0;
    end else if (inhibit || lock) begin
      // A key caught by a conflict or a mode change must be re-pressed.
      locked_n = 1'b1;
      active_n = 1'b0;
      rep_n    = 1'b0;
      cnt_n    = '0;
    end else if (locked_q) begin
      cnt_n = '0;
    end else if (press) begin
      fire     = 1'b1;
      active_n = 1'b1;
      rep_n    = 1'b0;
      cnt_n    = CNT_W'(1);
    end else if (active_q) begin
      if (!rep_q && cnt_q == CNT_W'(HOLD_CYCLES)) begin
        fire  = 1'b1;
        rep_n = 1'b1;
        cnt_n = CNT_W'(1);
      end else if (rep_q && cnt_q == CNT_W'(REPEAT_CYCLES)) begin
        fire  = 1'b1;
        cnt_n = CNT_W'(1);
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  // Key state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b1;
      locked_q <= 1'b0;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= lvl;
      locked_q <= locked_n;
      active_q <= active_n;
      rep_q    <= rep_n;
      cnt_q    <= cnt_n;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM and key sequencing: adjust pulses, seconds clear, run enable, digit blink.
// Latency: 1 cycle from key level to registered pulse / mode change.
// Backpressure: none; pulses are single-cycle and unconditional.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  time_set_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);

  // Every repeat must reload the timeout before it can expire.
  if (CLK_HZ < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || BLINK_CYCLES < 1 ||
      TIMEOUT_CYCLES <= max_int(HOLD_CYCLES, REPEAT_CYCLES)) begin : g_bad_params
    $error("time_set_ctrl: inconsistent timing parameters");
  end

  logic             mode_prev_q;
  logic             mode_press;
  logic             conflict;
  logic             up_press, dn_press;
  logic             up_fire, dn_fire;
  logic             any_press;
  logic             tmo_fire;
  logic             mode_chg;
  mode_t            mode_q, mode_n;
  adj_t             adj_q, adj_n;
  logic             sec_clear_q, sec_clear_n;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [BLK_W-1:0] blink_cnt_q;
  logic             phase_q;
  logic [BM_W-1:0]  blink_mask;

  assign mode_press = bus.mode_lvl & ~mode_prev_q;
  assign conflict   = bus.up_lvl & bus.dn_lvl;
  assign any_press  = mode_press | up_press | dn_press;

  // A press landing on the expiry cycle reloads instead of timing out.
  assign tmo_fire = (mode_q != MODE_RUN) &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !any_press;
  assign mode_chg = mode_press | tmo_fire;

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl    (bus.up_lvl),
    .inhibit(conflict),
    .lock   (mode_chg),
    .press  (up_press),
    .fire   (up_fire)
  );

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dn_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl    (bus.dn_lvl),
    .inhibit(conflict),
    .lock   (mode_chg),
    .press  (dn_press),
    .fire   (dn_fire)
  );

  // Mode key edge detect; resets high so a held key gives no press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_prev_q <= 1'b1;
    else        mode_prev_q <= bus.mode_lvl;
  end

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_RUN;
    else        mode_q <= mode_n;
  end

  // Next mode, seconds clear and adjust routing; a mode press wins over keys.
  always_comb begin
    mode_n      = mode_q;
    sec_clear_n = 1'b0;
    adj_n       = '0;
    case (mode_q)
      MODE_RUN: begin
        if (mode_press) mode_n = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        if (mode_press) begin
          mode_n = MODE_SET_MIN;
        end else if (tmo_fire) begin
          mode_n = MODE_RUN;
        end else begin
          adj_n.hour_inc = up_fire;
          adj_n.hour_dec = dn_fire;
        end
      end
      MODE_SET_MIN: begin
        if (mode_press) begin
          mode_n      = MODE_RUN;
          sec_clear_n = 1'b1;
        end else if (tmo_fire) begin
          mode_n = MODE_RUN;
        end else begin
          adj_n.min_inc = up_fire;
          adj_n.min_dec = dn_fire;
        end
      end
      default: mode_n = MODE_RUN;
    endcase
  end

  // Registered single-cycle command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_q       <= '0;
      sec_clear_q <= 1'b0;
    end else begin
      adj_q       <= adj_n;
      sec_clear_q <= sec_clear_n;
    end
  end

  // Idle timeout: held at zero in RUN, reloaded by any press or repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (mode_n == MODE_RUN) begin
      tmo_cnt_q <= '0;
    end else if (any_press || up_fire || dn_fire) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Blink phase: restarts visible on mode entry and on every adjust pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (mode_n == MODE_RUN || mode_n != mode_q || (|adj_n)) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLK_W'(1);
    end
  end

  // Only the digit pair being set blinks; everything else stays lit.
  always_comb begin
    blink_mask                   = '1;
    blink_mask[BM_SEC_LSB +: 2]  = 2'b11;
    case (mode_q)
      MODE_SET_HR:  blink_mask[BM_HR_LSB +: 2]  = {2{phase_q}};
      MODE_SET_MIN: blink_mask[BM_MIN_LSB +: 2] = {2{phase_q}};
      default:      blink_mask                  = '1;
    endcase
  end

  assign bus.hour_inc   = adj_q.hour_inc;
  assign bus.hour_dec   = adj_q.hour_dec;
  assign bus.min_inc    = adj_q.min_inc;
  assign bus.min_dec    = adj_q.min_dec;
  assign bus.sec_clear  = sec_clear_q;
  assign bus.run_en     = (mode_q == MODE_RUN);
  assign bus.blink_mask = blink_mask;
  assign bus.mode       = mode_q;

endmodule
